mandelbrot_frame_sched: RTL and testbench

//  Frame scheduler for the pipelined mandelbrot core. On start, feeds pixel

---
 rtl/mandelbrot_frame_sched.sv | 133 +++++++++++++
 tb/tb_mandelbrot_frame_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_frame_sched.sv
// Frame scheduler for the pipelined mandelbrot core: issues raster-order pixel
// coordinates, retires possibly out-of-order results into a framebuffer.
module mandelbrot_frame_sched #(
  parameter int RESX   = 8,
  parameter int RESY   = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic              err,
  output logic              core_valid,
  input  logic              next_in,
  output logic [10:0]       xin,
  output logic [10:0]       yin,
  input  logic              next_out,
  input  logic [10:0]       xout,
  input  logic [10:0]       yout,
  input  logic [15:0]       i,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data
);

  localparam logic [21:0] LAST_PIX = 22'(RESX * RESY - 1);
  localparam logic [10:0] XLAST    = 11'(RESX - 1);
  localparam logic [32:0] DMAX     = (33'd1 << DATA_W) - 33'd1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      state;
  logic [21:0] issued;
  logic [22:0] inflight;
  logic        abort_seen;
  logic        accept;
  logic        in_range;

  assign accept   = next_in & core_valid;
  assign in_range = (xout < 11'(RESX)) && (yout < 11'(RESY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      issued     <= '0;
      inflight   <= '0;
      abort_seen <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= '0;
      err        <= 1'b0;
      core_valid <= 1'b0;
      xin        <= '0;
      yin        <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
    end else begin
      done  <= 1'b0;
      fb_we <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_ISSUE;
            busy       <= 1'b1;
            core_valid <= 1'b1;
            xin        <= '0;
            yin        <= '0;
            issued     <= '0;
            abort_seen <= 1'b0;
            err        <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            issued <= issued + 22'd1;
            if (issued == LAST_PIX) begin
              xin <= '0;
              yin <= '0;
            end else if (xin == XLAST) begin
              xin <= '0;
              yin <= yin + 11'd1;
            end else begin
              xin <= xin + 11'd1;
            end
          end
          if (abort || (accept && issued == LAST_PIX)) begin
            state      <= S_DRAIN;
            core_valid <= 1'b0;
            abort_seen <= abort;
          end
        end
        S_DRAIN: begin
          if (abort) abort_seen <= 1'b1;
          if (inflight == '0) begin
            busy <= 1'b0;
            if (abort_seen || abort) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Retire bookkeeping sits after the FSM so a result error in the same
      // cycle as an accepted start still leaves err set.
      if (accept && !next_out) begin
        inflight <= inflight + 23'd1;
      end else if (!accept && next_out) begin
        if (inflight == '0) err <= 1'b1;
        else inflight <= inflight - 23'd1;
      end

      if (next_out) begin
        fb_addr <= ADDR_W'(23'(yout) * 23'(RESX) + 23'(xout));
        fb_data <= ({17'd0, i} > DMAX) ? '1 : DATA_W'(i);
        if (in_range) fb_we <= 1'b1;
        else err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_frame_sched.sv
// Directed bench for mandelbrot_frame_sched with a behavioural core model
// driven cycle by cycle from the test tasks.
module tb_mandelbrot_frame_sched;

  logic        clk, rst_n, start, abort;
  logic        busy, done, err, core_valid, next_in, next_out, fb_we;
  logic [15:0] frame_cnt, i;
  logic [10:0] xin, yin, xout, yout;
  logic [5:0]  fb_addr;
  logic [7:0]  fb_data;

  mandelbrot_frame_sched #(.RESX(8), .RESY(8), .DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .done(done), .frame_cnt(frame_cnt), .err(err), .core_valid(core_valid),
    .next_in(next_in), .xin(xin), .yin(yin), .next_out(next_out),
    .xout(xout), .yout(yout), .i(i), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] iv;
  } res_t;

  res_t        sched[$];
  res_t        rowbuf[$];
  logic [5:0]  wlog_addr[$];
  logic [7:0]  wlog_data[$];
  int          wr_map[64];
  int cmp, fails;
  int c, s, last_due, delay;
  int acc_cnt, order_err, exp_x, exp_y, last_acc_edge;
  int wr_cnt, last_wr_edge, data_err, done_cnt, done_edge;
  bit auto_core, reverse, toggle, busy_seen;

  task automatic push_sched(input logic [10:0] x, input logic [10:0] y, input logic [15:0] iv);
    res_t r;
    int   due;
    due = c + delay;
    if (due <= last_due) due = last_due + 1;
    last_due = due;
    r.due = due; r.x = x; r.y = y; r.iv = iv;
    sched.push_back(r);
  endtask

  // Predicts the accept at the coming edge c, drives the core result due at
  // edge c, then observes DUT outputs 1 time unit after that edge.
  task automatic tick();
    res_t r;
    if (toggle) next_in = ~next_in;
    if (next_in && core_valid) begin
      acc_cnt++;
      last_acc_edge = c;
      if (xin !== 11'(exp_x) || yin !== 11'(exp_y)) order_err++;
      exp_x++;
      if (exp_x == 8) begin exp_x = 0; exp_y++; end
      if (auto_core) begin
        r.due = 0; r.x = xin; r.y = yin; r.iv = 16'(yin * 8 + xin);
        if (reverse) begin
          rowbuf.push_back(r);
          if (xin == 11'd7)
            while (rowbuf.size() > 0) begin
              r = rowbuf.pop_back();
              push_sched(r.x, r.y, r.iv);
            end
        end else begin
          push_sched(r.x, r.y, r.iv);
        end
      end
    end
    if (sched.size() > 0 && sched[0].due == c) begin
      r = sched.pop_front();
      next_out = 1'b1; xout = r.x; yout = r.y; i = r.iv;
    end else begin
      next_out = 1'b0;
    end
    @(posedge clk);
    #1;
    if (fb_we) begin
      wr_cnt++;
      last_wr_edge = c;
      wr_map[int'(fb_addr)]++;
      wlog_addr.push_back(fb_addr);
      wlog_data.push_back(fb_data);
      if (auto_core && fb_data !== 8'(fb_addr)) data_err++;
    end
    if (done) begin done_cnt++; done_edge = c; end
    busy_seen = busy;
    c++;
  endtask

  task automatic clear_stats();
    acc_cnt = 0; order_err = 0; exp_x = 0; exp_y = 0; last_acc_edge = -1;
    wr_cnt = 0; last_wr_edge = -1; data_err = 0; done_cnt = 0; done_edge = -1;
    for (int k = 0; k < 64; k++) wr_map[k] = 0;
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic begin_frame();
    clear_stats();
    start = 1'b1;
    s = c;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int bound, input string nm);
    int n;
    n = 0;
    while (busy_seen && n < bound) begin tick(); n++; end
    cmp++;
    if (busy_seen) begin
      fails++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, need 0", nm, busy_seen, bound);
    end
    repeat (3) tick();
  endtask

  function automatic int bad_map();
    int b;
    b = 0;
    for (int k = 0; k < 64; k++) if (wr_map[k] != 1) b++;
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cmp++; if ({busy, done, err, core_valid, fb_we} !== 5'b0) begin fails++;
      $display("FAIL reset_flags: got %b need 00000", {busy, done, err, core_valid, fb_we}); end
    cmp++; if ({xin, yin} !== 22'd0) begin fails++;
      $display("FAIL reset_xy: got %0d,%0d need 0,0", xin, yin); end
    cmp++; if (frame_cnt !== 16'd0) begin fails++;
      $display("FAIL reset_frame_cnt: got %0d need 0", frame_cnt); end
    cmp++; if ({fb_addr, fb_data} !== 14'd0) begin fails++;
      $display("FAIL reset_fb: got addr %0d data %0d need 0,0", fb_addr, fb_data); end
  endtask

  task automatic test_frame();
    delay = 3; auto_core = 1; reverse = 0; toggle = 0; next_in = 1'b1;
    begin_frame();
    run_until_idle(200, "frame");
    cmp++; if (acc_cnt != 64 || order_err != 0) begin fails++;
      $display("FAIL frame_accepts: got %0d (order errs %0d) need 64 (0)", acc_cnt, order_err); end
    cmp++; if (last_acc_edge - s != 64) begin fails++;
      $display("FAIL frame_issue_len: got %0d need 64", last_acc_edge - s); end
    cmp++; if (wr_cnt != 64 || bad_map() != 0 || data_err != 0) begin fails++;
      $display("FAIL frame_writes: got %0d (bad addr %0d, bad data %0d) need 64 (0,0)", wr_cnt, bad_map(), data_err); end
    // start edge counted as cycle 0: 64 accepts + 3 core latency + 1 drain check
    cmp++; if (done_cnt != 1 || done_edge - s != 68) begin fails++;
      $display("FAIL frame_done: got count %0d at %0d need 1 at 68", done_cnt, done_edge - s); end
    cmp++; if (frame_cnt !== 16'd1 || err !== 1'b0) begin fails++;
      $display("FAIL frame_cnt_err: got cnt %0d err %b need 1, 0", frame_cnt, err); end
  endtask

  task automatic test_reverse();
    delay = 3; auto_core = 1; reverse = 1; toggle = 0; next_in = 1'b1;
    begin_frame();
    run_until_idle(300, "reverse");
    reverse = 0;
    cmp++; if (wr_cnt != 64 || bad_map() != 0 || data_err != 0) begin fails++;
      $display("FAIL reverse_writes: got %0d (bad addr %0d, bad data %0d) need 64 (0,0)", wr_cnt, bad_map(), data_err); end
    cmp++; if (done_cnt != 1 || done_edge != last_wr_edge + 1) begin fails++;
      $display("FAIL reverse_done: got count %0d at %0d need 1 at %0d", done_cnt, done_edge, last_wr_edge + 1); end
    cmp++; if (err !== 1'b0 || frame_cnt !== 16'd2) begin fails++;
      $display("FAIL reverse_err_cnt: got err %b cnt %0d need 0, 2", err, frame_cnt); end
  endtask

  task automatic test_toggle();
    delay = 3; auto_core = 1; toggle = 1; next_in = 1'b0;
    begin_frame();
    repeat (30) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_idle(400, "toggle");
    toggle = 0;
    cmp++; if (acc_cnt != 64 || order_err != 0) begin fails++;
      $display("FAIL toggle_accepts: got %0d (order errs %0d) need 64 (0)", acc_cnt, order_err); end
    cmp++; if (last_acc_edge - s != 128) begin fails++;
      $display("FAIL toggle_issue_len: got %0d need 128", last_acc_edge - s); end
    cmp++; if (wr_cnt != 64 || bad_map() != 0 || done_cnt != 1 || frame_cnt !== 16'd3) begin fails++;
      $display("FAIL toggle_result: got writes %0d bad %0d done %0d cnt %0d need 64,0,1,3", wr_cnt, bad_map(), done_cnt, frame_cnt); end
  endtask

  task automatic test_stray();
    auto_core = 0; delay = 1; next_in = 1'b0;
    clear_stats();
    push_sched(11'd3, 11'd1, 16'd40);
    repeat (4) tick();
    cmp++; if (wlog_addr.size() != 1 || wlog_addr[0] !== 6'd11 || wlog_data[0] !== 8'd40) begin fails++;
      $display("FAIL stray_write: got %0d writes need 1 to addr 11 data 40", wlog_addr.size()); end
    cmp++; if (err !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL stray_err: got err %b busy %b need 1, 0", err, busy); end
  endtask

  task automatic test_abort();
    int wr_at_abort;
    delay = 5; auto_core = 1; toggle = 0; next_in = 1'b1;
    begin_frame();
    repeat (19) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wr_at_abort = wr_cnt;
    run_until_idle(100, "abort");
    cmp++; if (acc_cnt != 20 || last_acc_edge - s != 20) begin fails++;
      $display("FAIL abort_accepts: got %0d last at %0d need 20 at 20", acc_cnt, last_acc_edge - s); end
    cmp++; if (wr_at_abort != 15 || wr_cnt - wr_at_abort != 5) begin fails++;
      $display("FAIL abort_drain_writes: got %0d then %0d need 15 then 5", wr_at_abort, wr_cnt - wr_at_abort); end
    cmp++; if (done_cnt != 0 || frame_cnt !== 16'd3 || busy !== 1'b0) begin fails++;
      $display("FAIL abort_no_done: got done %0d cnt %0d busy %b need 0,3,0", done_cnt, frame_cnt, busy); end
    cmp++; if (err !== 1'b0) begin fails++;
      $display("FAIL abort_err_cleared: got %b need 0", err); end
  endtask

  task automatic test_sat_err();
    auto_core = 0; delay = 3; toggle = 0; next_in = 1'b0;
    begin_frame();
    next_in = 1'b1;
    repeat (3) tick();
    next_in = 1'b0;
    cmp++; if (acc_cnt != 3 || order_err != 0) begin fails++;
      $display("FAIL sat_accepts: got %0d (order errs %0d) need 3 (0)", acc_cnt, order_err); end
    push_sched(11'd1, 11'd2, 16'd300);
    push_sched(11'd0, 11'd0, 16'd17);
    push_sched(11'd8, 11'd0, 16'd5);
    repeat (8) tick();
    cmp++; if (wlog_addr.size() != 2) begin fails++;
      $display("FAIL sat_write_count: got %0d need 2", wlog_addr.size()); end
    else begin
      cmp++; if (wlog_addr[0] !== 6'd17 || wlog_data[0] !== 8'd255) begin fails++;
        $display("FAIL sat_i300: got addr %0d data %0d need 17, 255", wlog_addr[0], wlog_data[0]); end
      cmp++; if (wlog_addr[1] !== 6'd0 || wlog_data[1] !== 8'd17) begin fails++;
        $display("FAIL sat_i17: got addr %0d data %0d need 0, 17", wlog_addr[1], wlog_data[1]); end
    end
    cmp++; if (err !== 1'b1) begin fails++;
      $display("FAIL range_err: got %b need 1", err); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_until_idle(50, "sat_abort");
    cmp++; if (done_cnt != 0 || err !== 1'b1) begin fails++;
      $display("FAIL sat_abort_state: got done %0d err %b need 0, 1", done_cnt, err); end
    begin_frame();
    cmp++; if (err !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL start_clears_err: got err %b busy %b need 0, 1", err, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_until_idle(50, "clear_abort");
  endtask

  task automatic test_reset_mid();
    delay = 3; auto_core = 1; toggle = 0; next_in = 1'b1;
    begin_frame();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    cmp++; if ({busy, done, err, core_valid, fb_we, xin, yin, frame_cnt, fb_addr, fb_data} !== 65'd0) begin fails++;
      $display("FAIL midreset_outputs: got busy %b cv %b xin %0d yin %0d cnt %0d need all 0", busy, core_valid, xin, yin, frame_cnt); end
    sched.delete();
    rowbuf.delete();
    last_due = 0;
    next_out = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    begin_frame();
    run_until_idle(200, "midreset");
    cmp++; if (acc_cnt != 64 || order_err != 0 || wr_cnt != 64 || bad_map() != 0) begin fails++;
      $display("FAIL midreset_frame: got acc %0d ord %0d wr %0d bad %0d need 64,0,64,0", acc_cnt, order_err, wr_cnt, bad_map()); end
    cmp++; if (done_cnt != 1 || frame_cnt !== 16'd1) begin fails++;
      $display("FAIL midreset_done: got done %0d cnt %0d need 1, 1", done_cnt, frame_cnt); end
  endtask

  initial begin
    cmp = 0; fails = 0; c = 0; last_due = 0; delay = 3;
    auto_core = 0; reverse = 0; toggle = 0; busy_seen = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; next_in = 1'b0;
    next_out = 1'b0; xout = '0; yout = '0; i = '0;
    clear_stats();
    test_reset();
    test_frame();
    test_reverse();
    test_toggle();
    test_stray();
    test_abort();
    test_sat_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
